// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if
//   Bundles the instruction-memory handshake, the decode handshake and the
//   branch-redirect inputs of the fetch sequencer.
//   master : the sequencer side (drives requests, instructions, misalign)
//   slave  : the environment side (memory, decode stage, branch unit)
interface pc_fetch_sequencer_if #(
  parameter int unsigned N = 32
);
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [N-1:0] imem_addr;
  logic         imem_resp_valid;
  logic [31:0]  imem_resp_data;
  logic         inst_valid;
  logic         inst_ready;
  logic [31:0]  inst_out;
  logic [N-1:0] inst_pc;
  logic         branch_valid;
  logic         branch_taken;
  logic [N-1:0] branch_target;
  logic         misalign;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    output inst_valid,
    input  inst_ready,
    output inst_out,
    output inst_pc,
    input  branch_valid,
    input  branch_taken,
    input  branch_target,
    output misalign
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_addr,
    output imem_resp_valid,
    output imem_resp_data,
    input  inst_valid,
    output inst_ready,
    input  inst_out,
    input  inst_pc,
    output branch_valid,
    output branch_taken,
    output branch_target,
    input  misalign
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Holds the architectural PC, issues one instruction fetch at a time and
//   presents each fetched word with its PC to decode. A taken branch loads
//   branch_target and squashes any fetch still in flight.
// Ports
//   clk : clock, all state on the rising edge
//   rst : asynchronous, active-low reset
//   bus : pc_fetch_sequencer_if.master (imem request/response, decode
//         handshake, branch redirect, misalign flag)
// Build option
//   PC_SEQ_MISALIGN_CHECK_EN : misaligned redirect targets are ignored and
//   raise the sticky misalign flag. Undefined: target bits [1:0] are forced
//   to zero and misalign stays 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// REQ     | request at PC presented, waiting for imem_req_ready
// WAIT    | request accepted, waiting for imem_resp_valid
// DELIVER | instruction held on inst_out until decode accepts it
// DRAIN   | squashed fetch outstanding, its response will be dropped
module pc_fetch_sequencer #(
  parameter int unsigned  N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_fetch_sequencer_if.master bus
);
  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DELIVER = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [N-1:0] inst_pc_q, inst_pc_d;
  logic         misalign_q, misalign_d;
  logic         run_q;
  logic         req_valid;
  logic         req_fire;
  logic         redirect_raw;
  logic         redirect;
  logic [N-1:0] target;

  assign redirect_raw = bus.branch_valid && bus.branch_taken;

`ifdef PC_SEQ_MISALIGN_CHECK_EN
  assign redirect   = redirect_raw && (bus.branch_target[1:0] == 2'b00);
  assign target     = bus.branch_target;
  assign misalign_d = misalign_q | (redirect_raw && (bus.branch_target[1:0] != 2'b00));
`else
  logic unused_tgt_lo;
  assign unused_tgt_lo = ^bus.branch_target[1:0];
  assign redirect   = redirect_raw;
  assign target     = {bus.branch_target[N-1:2], 2'b00};
  assign misalign_d = 1'b0;
`endif

  // run_q keeps the request low through reset and for the release cycle,
  // so the first request appears the cycle after rst deasserts.
  assign req_valid = (state_q == S_REQ) && run_q;
  assign req_fire  = req_valid && bus.imem_req_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d    = target;
          // an accepted request still owes a response
          state_d = req_fire ? S_DRAIN : S_REQ;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d    = target;
          state_d = bus.imem_resp_valid ? S_REQ : S_DRAIN;
        end else if (bus.imem_resp_valid) begin
          inst_d    = bus.imem_resp_data;
          inst_pc_d = pc_q;
          state_d   = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + N'(4);
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          pc_d = target;
        end
        if (bus.imem_resp_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      misalign_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      misalign_q <= misalign_d;
      run_q      <= 1'b1;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = (state_q == S_DELIVER);
  assign bus.inst_out       = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.misalign       = misalign_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic clk;
  logic rst;

  pc_fetch_sequencer_if #(.N(32)) ifc ();
  pc_fetch_sequencer_if #(.N(32)) wif ();

  pc_fetch_sequencer #(.N(32), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  pc_fetch_sequencer #(.N(32), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // instruction memory contents: a distinct word per address
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  // ---------------- memory model for the main DUT ----------------
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  initial begin
    ifc.imem_resp_valid = 1'b0;
    ifc.imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      ifc.imem_resp_valid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          ifc.imem_resp_valid = 1'b1;
          ifc.imem_resp_data  = memf(mem_addr);
        end
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  // Architectural view: the next fetch address is the last redirect target
  // or the previous accepted instruction's PC + 4; every presented
  // instruction must be the memory word at that address.
  logic [31:0] exp_pc = RST_PC;
  logic        exp_mis = 1'b0;
  logic        busy = 1'b0;
  logic        hold_prev = 1'b0;
  logic [31:0] held_pc, held_data;
  logic        m_raw, m_redir;
  logic [31:0] acc_addr_q[$];
  int          acc_cyc_q[$];
  logic [31:0] hs_pc_q[$];
  int          hs_cyc_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(ifc.inst_valid), 32'd0);
      chk("rst_inst_out", ifc.inst_out, 32'd0);
      chk("rst_inst_pc", ifc.inst_pc, 32'd0);
      chk("rst_misalign", 32'(ifc.misalign), 32'd0);
      exp_pc    = RST_PC;
      exp_mis   = 1'b0;
      busy      = 1'b0;
      hold_prev = 1'b0;
      mem_cnt   = 0;
    end else begin
      if (ifc.imem_resp_valid) busy = 1'b0;
      if (ifc.imem_req_valid) begin
        chk("req_addr", ifc.imem_addr, exp_pc);
        chk("req_while_busy", 32'(busy), 32'd0);
        if (ifc.imem_req_ready) begin
          busy     = 1'b1;
          mem_cnt  = mem_lat;
          mem_addr = ifc.imem_addr;
          acc_addr_q.push_back(ifc.imem_addr);
          acc_cyc_q.push_back(cyc);
        end
      end
      if (hold_prev) begin
        chk("hold_valid", 32'(ifc.inst_valid), 32'd1);
        chk("hold_pc", ifc.inst_pc, held_pc);
        chk("hold_data", ifc.inst_out, held_data);
      end
      if (ifc.inst_valid) begin
        chk("inst_pc", ifc.inst_pc, exp_pc);
        chk("inst_data", ifc.inst_out, memf(exp_pc));
        chk("valid_and_req", 32'(ifc.imem_req_valid), 32'd0);
      end
      chk("misalign", 32'(ifc.misalign), 32'(exp_mis));
      m_raw = ifc.branch_valid && ifc.branch_taken;
`ifdef PC_SEQ_MISALIGN_CHECK_EN
      m_redir = m_raw && (ifc.branch_target[1:0] == 2'b00);
      if (m_raw && (ifc.branch_target[1:0] != 2'b00)) exp_mis = 1'b1;
`else
      m_redir = m_raw;
`endif
      hold_prev = ifc.inst_valid && !ifc.inst_ready && !m_redir;
      held_pc   = ifc.inst_pc;
      held_data = ifc.inst_out;
      if (ifc.inst_valid && ifc.inst_ready) begin
        hs_pc_q.push_back(ifc.inst_pc);
        hs_cyc_q.push_back(cyc);
      end
      if (m_redir) exp_pc = {ifc.branch_target[31:2], 2'b00};
      else if (ifc.inst_valid && ifc.inst_ready) exp_pc = exp_pc + 32'd4;
    end
  end

  // ---------------- wrap-around DUT environment ----------------
  logic        w_pend = 1'b0;
  logic [31:0] w_addr = '0;
  logic [31:0] w_acc_q[$];
  logic [31:0] w_hs_q[$];

  initial begin
    wif.imem_req_ready  = 1'b1;
    wif.inst_ready      = 1'b1;
    wif.branch_valid    = 1'b0;
    wif.branch_taken    = 1'b0;
    wif.branch_target   = '0;
    wif.imem_resp_valid = 1'b0;
    wif.imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      wif.imem_resp_valid = w_pend;
      wif.imem_resp_data  = memf(w_addr);
      w_pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      w_pend = 1'b0;
    end else begin
      if (wif.imem_req_valid && wif.imem_req_ready) begin
        w_pend = 1'b1;
        w_addr = wif.imem_addr;
        w_acc_q.push_back(wif.imem_addr);
      end
      if (wif.inst_valid && wif.inst_ready) begin
        w_hs_q.push_back(wif.inst_pc);
        chk("wrap_data", wif.inst_out, memf(wif.inst_pc));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      if (ifc.imem_req_valid) break;
      tick();
    end
    chk(name, 32'(ifc.imem_req_valid), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      if (ifc.inst_valid) break;
      tick();
    end
    chk(name, 32'(ifc.inst_valid), 32'd1);
  endtask

  task automatic wait_hs(input int target, input string name);
    int i;
    for (i = 0; i < 80; i++) begin
      if (hs_pc_q.size() >= target) break;
      tick();
    end
    chk(name, 32'(hs_pc_q.size() >= target), 32'd1);
  endtask

  task automatic branch(input logic taken, input logic [31:0] tgt);
    ifc.branch_valid  = 1'b1;
    ifc.branch_taken  = taken;
    ifc.branch_target = tgt;
  endtask

  task automatic no_branch();
    ifc.branch_valid  = 1'b0;
    ifc.branch_taken  = 1'b0;
    ifc.branch_target = '0;
  endtask

  int ba, bh, i;

  initial begin
    rst = 1'b0;
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b1;
    no_branch();
    tick();
    tick();
    chk("reset_addr", ifc.imem_addr, RST_PC);
    chk("reset_inst_out", ifc.inst_out, 32'd0);

    // A: sequential fetch, then taken branch in DELIVER at 0x8, then not-taken
    rst = 1'b1;
    ba = acc_addr_q.size();
    bh = hs_pc_q.size();
    tick();
    chk("first_req_after_release", 32'(ifc.imem_req_valid), 32'd1);
    for (i = 0; i < 40; i++) begin
      if (ifc.inst_valid && ifc.inst_pc == 32'h8) break;
      tick();
    end
    chk("deliver_pc8_reached", ifc.inst_pc, 32'h8);
    branch(1'b1, 32'h100);
    tick();
    branch(1'b0, 32'h200);
    wait_hs(bh + 5, "a_hs_timeout");
    no_branch();
    chk("a_acc0", acc_addr_q[ba], 32'h0);
    chk("a_acc1", acc_addr_q[ba+1], 32'h4);
    chk("a_acc2", acc_addr_q[ba+2], 32'h8);
    chk("a_acc3", acc_addr_q[ba+3], 32'h100);
    chk("a_acc4", acc_addr_q[ba+4], 32'h104);
    chk("a_spacing1", 32'(acc_cyc_q[ba+1] - acc_cyc_q[ba]), 32'd3);
    chk("a_spacing2", 32'(acc_cyc_q[ba+2] - acc_cyc_q[ba+1]), 32'd3);
    for (int k = 0; k < 3; k++) chk("a_latency", 32'(hs_cyc_q[bh+k] - acc_cyc_q[ba+k]), 32'd2);
    chk("a_hs0", hs_pc_q[bh], 32'h0);
    chk("a_hs1", hs_pc_q[bh+1], 32'h4);
    chk("a_hs2", hs_pc_q[bh+2], 32'h8);
    chk("a_hs3", hs_pc_q[bh+3], 32'h100);
    chk("a_hs4", hs_pc_q[bh+4], 32'h104);

    // reset asserted in the middle of WAIT
    wait_req("pre_rst_req");
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("async_inst_valid", 32'(ifc.inst_valid), 32'd0);
    chk("async_inst_out", ifc.inst_out, 32'd0);
    chk("async_inst_pc", ifc.inst_pc, 32'd0);
    chk("async_addr", ifc.imem_addr, RST_PC);
    chk("async_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    ifc.inst_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("restart_req", 32'(ifc.imem_req_valid), 32'd1);
    chk("restart_addr", ifc.imem_addr, RST_PC);

    // B: backpressure at PC 0x4
    wait_valid("b_valid0");
    chk("b_pc0", ifc.inst_pc, 32'h0);
    chk("b_data0", ifc.inst_out, 32'hC3A5_FFFF);
    ifc.inst_ready = 1'b1;
    tick();
    ifc.inst_ready = 1'b0;
    wait_valid("b_valid4");
    for (i = 0; i < 6; i++) begin
      chk("b_hold_valid", 32'(ifc.inst_valid), 32'd1);
      chk("b_hold_pc", ifc.inst_pc, 32'h4);
      chk("b_hold_data", ifc.inst_out, 32'hC3A1_FFFB);
      chk("b_no_req", 32'(ifc.imem_req_valid), 32'd0);
      chk("b_pc_reg", ifc.imem_addr, 32'h4);
      if (i < 5) tick();
    end
    ifc.inst_ready = 1'b1;
    mem_lat = 3;
    tick();
    chk("b_next_addr", ifc.imem_addr, 32'h8);

    // C: taken branch in WAIT before the response arrives
    wait_req("c_req");
    ba = acc_addr_q.size();
    bh = hs_pc_q.size();
    tick();
    branch(1'b1, 32'h24);
    tick();
    no_branch();
    wait_hs(bh + 2, "c_hs_timeout");
    chk("c_acc0", acc_addr_q[ba], 32'h8);
    chk("c_acc1", acc_addr_q[ba+1], 32'h24);
    chk("c_acc2", acc_addr_q[ba+2], 32'h28);
    chk("c_hs0", hs_pc_q[bh], 32'h24);
    chk("c_hs1", hs_pc_q[bh+1], 32'h28);

    // taken branch in WAIT coincident with the response
    mem_lat = 1;
    wait_req("w_req");
    ba = acc_addr_q.size();
    bh = hs_pc_q.size();
    tick();
    branch(1'b1, 32'h40);
    tick();
    no_branch();
    wait_hs(bh + 1, "w_hs_timeout");
    chk("w_acc0", acc_addr_q[ba], 32'h2C);
    chk("w_acc1", acc_addr_q[ba+1], 32'h40);
    chk("w_hs0", hs_pc_q[bh], 32'h40);

    // taken branch in REQ while the request is accepted
    wait_req("r_req");
    ba = acc_addr_q.size();
    bh = hs_pc_q.size();
    branch(1'b1, 32'h60);
    tick();
    no_branch();
    wait_hs(bh + 1, "r_hs_timeout");
    chk("r_acc0", acc_addr_q[ba], 32'h44);
    chk("r_acc1", acc_addr_q[ba+1], 32'h60);
    chk("r_hs0", hs_pc_q[bh], 32'h60);

    // taken branch in REQ with memory not ready, then a misaligned target
    ifc.imem_req_ready = 1'b0;
    branch(1'b1, 32'h80);
    tick();
    no_branch();
    chk("nr_addr", ifc.imem_addr, 32'h80);
    chk("nr_req_valid", 32'(ifc.imem_req_valid), 32'd1);
    branch(1'b1, 32'h26);
    tick();
    no_branch();
`ifdef PC_SEQ_MISALIGN_CHECK_EN
    chk("mis_addr", ifc.imem_addr, 32'h80);
    chk("mis_flag", 32'(ifc.misalign), 32'd1);
`else
    chk("mis_addr", ifc.imem_addr, 32'h24);
    chk("mis_flag", 32'(ifc.misalign), 32'd0);
`endif
    ifc.imem_req_ready = 1'b1;
    bh = hs_pc_q.size();
    wait_hs(bh + 1, "mis_hs_timeout");
`ifdef PC_SEQ_MISALIGN_CHECK_EN
    chk("mis_hs", hs_pc_q[bh], 32'h80);
`else
    chk("mis_hs", hs_pc_q[bh], 32'h24);
`endif

    // wrap-around instance
    chk("wrap_acc_count", 32'(w_acc_q.size() >= 2), 32'd1);
    chk("wrap_acc0", w_acc_q[0], 32'hFFFF_FFFC);
    chk("wrap_acc1", w_acc_q[1], 32'h0);
    chk("wrap_hs0", w_hs_q[0], 32'hFFFF_FFFC);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
